// File: rtl/multi_ch_trg.sv
// Multi-channel ADC threshold trigger: per-channel hit detection, pre/post gating
// of a delayed word stream, frame length cap and hit-time capture.
module multi_ch_trg #(
  parameter int N_CH                 = 2,
  parameter int PRE_ACQUI_LEN        = 4,
  parameter int POST_ACQUI_LEN       = 38,
  parameter int ACQUI_LEN            = 100,
  parameter int TIME_STAMP_WIDTH     = 48,
  parameter int ADC_RESOLUTION_WIDTH = 12,
  parameter int TDATA_WIDTH          = 128
) (
  input  logic                                         CLK,
  input  logic                                         RESET,
  input  logic [N_CH*TDATA_WIDTH-1:0]                  TDATA,
  input  logic [N_CH-1:0]                              TVALID,
  input  logic [N_CH*(ADC_RESOLUTION_WIDTH+1)-1:0]     THRESHOLD_VAL,
  input  logic [N_CH*ADC_RESOLUTION_WIDTH-1:0]         BASELINE,
  input  logic [N_CH-1:0]                              POLARITY,
  input  logic [TIME_STAMP_WIDTH-1:0]                  CURRENT_TIME,
  output logic [N_CH*TIME_STAMP_WIDTH-1:0]             TIME_STAMP,
  output logic [N_CH*$clog2(TDATA_WIDTH/16)-1:0]       HIT_SAMPLE,
  output logic [N_CH*ADC_RESOLUTION_WIDTH-1:0]         BASELINE_WHEN_HIT,
  output logic [N_CH*(ADC_RESOLUTION_WIDTH+1)-1:0]     THRESHOLD_WHEN_HIT,
  output logic [N_CH-1:0]                              TRIGGERED,
  output logic [N_CH*TDATA_WIDTH-1:0]                  DATA,
  output logic [N_CH-1:0]                              VALID,
  output logic [N_CH-1:0]                              OVER_LEN
);

  localparam int SPT = TDATA_WIDTH / 16;
  localparam int IW  = $clog2(SPT);
  localparam int ARW = ADC_RESOLUTION_WIDTH;
  localparam int TSW = TIME_STAMP_WIDTH;
  localparam int PL  = PRE_ACQUI_LEN + 1;
  localparam int CW  = $clog2(ACQUI_LEN + 1);
  localparam int PW  = $clog2(POST_ACQUI_LEN + 1);

  typedef enum logic [1:0] {IDLE, ACQ, POST, HOLD} state_t;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n, pre_new;
    logic [PW-1:0]           post_cnt, post_n;
    logic [TDATA_WIDTH-1:0]  dline [PL];
    logic [PL-1:0]           vline, mline, oline;
    logic                    hit, cmp, start, mark_cur, over_cur;
    logic [IW-1:0]           hit_idx;
    logic [TDATA_WIDTH-1:0]  word_fmt;
    logic [ARW-1:0]          smp, base;
    logic signed [ARW:0]     delta, thr;
    logic [TSW-1:0]          ts_q;
    logic [IW-1:0]           hs_q;
    logic [ARW-1:0]          bl_q;
    logic [ARW:0]            th_q;

    assign base = BASELINE[c*ARW +: ARW];
    assign thr  = THRESHOLD_VAL[c*(ARW+1) +: ARW+1];

    // Descending scan so the lowest hit lane index wins.
    always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      word_fmt = '1;
      smp      = '0;
      delta    = '0;
      cmp      = 1'b0;
      for (int i = SPT - 1; i >= 0; i--) begin
        smp   = TDATA[c*TDATA_WIDTH + 16*i + 15 -: ARW];
        delta = $signed({smp[ARW-1], smp}) - $signed({base[ARW-1], base});
        cmp   = POLARITY[c] ? (delta <= thr) : (delta >= thr);
        if (TVALID[c]) begin
          word_fmt[16*i +: 16] = 16'(smp);
          if (cmp) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
          end
        end
      end
    end

    // Pre-words still unmarked in the delay line are the ones this frame may claim.
    always_comb begin
      pre_new = '0;
      for (int k = 0; k < PL - 1; k++)
        if (!mline[k]) pre_new = pre_new + 1'b1;
    end

    always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      post_n   = post_cnt;
      start    = 1'b0;
      mark_cur = 1'b0;
      over_cur = 1'b0;
      case (state)
        IDLE: begin
          if (hit) begin
            start    = 1'b1;
            mark_cur = 1'b1;
            cnt_n    = pre_new + 1'b1;
            post_n   = '0;
            state_n  = ACQ;
            if (cnt_n >= CW'(ACQUI_LEN)) begin
              over_cur = 1'b1;
              state_n  = HOLD;
            end
          end
        end
        ACQ, POST: begin
          mark_cur = 1'b1;
          cnt_n    = cnt + 1'b1;
          if (hit) begin
            post_n  = '0;
            state_n = ACQ;
          end else begin
            post_n  = post_cnt + 1'b1;
            state_n = (post_n == PW'(POST_ACQUI_LEN)) ? IDLE : POST;
          end
          if (cnt_n == CW'(ACQUI_LEN)) begin
            over_cur = 1'b1;
            post_n   = '0;
            state_n  = HOLD;
          end
        end
        HOLD: begin
          if (!hit) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end

    always_ff @(posedge CLK) begin
      if (RESET) begin
        state    <= IDLE;
        cnt      <= '0;
        post_cnt <= '0;
        for (int k = 0; k < PL; k++) dline[k] <= '1;
        vline    <= '0;
        mline    <= '0;
        oline    <= '0;
        ts_q     <= '0;
        hs_q     <= '0;
        bl_q     <= '0;
        th_q     <= '0;
      end else begin
        state    <= state_n;
        cnt      <= cnt_n;
        post_cnt <= post_n;
        dline[0] <= word_fmt;
        for (int k = 1; k < PL; k++) dline[k] <= dline[k-1];
        vline    <= {vline[PL-2:0], TVALID[c]};
        mline    <= {mline[PL-2:0] | {(PL-1){start}}, mark_cur};
        oline    <= {oline[PL-2:0], over_cur};
        if (start) begin
          ts_q <= CURRENT_TIME;
          hs_q <= hit_idx;
          bl_q <= base;
          th_q <= thr;
        end
      end
    end

    assign DATA[c*TDATA_WIDTH +: TDATA_WIDTH] = dline[PL-1];
    assign VALID[c]                           = vline[PL-1];
    assign TRIGGERED[c]                       = mline[PL-1];
    assign OVER_LEN[c]                        = oline[PL-1];
    assign TIME_STAMP[c*TSW +: TSW]           = ts_q;
    assign HIT_SAMPLE[c*IW +: IW]             = hs_q;
    assign BASELINE_WHEN_HIT[c*ARW +: ARW]    = bl_q;
    assign THRESHOLD_WHEN_HIT[c*(ARW+1) +: ARW+1] = th_q;
  end

endmodule
